video_timing_generator: RTL

//  Parametrised VGA/video timing generator: runtime-agnostic, compile-time-configurable
//  H/V timing, selectable sync polarity, pixel clock-enable, and a configurable sync/blank

---
 rtl/video_timing_pkg.sv | 61 ++++++
 rtl/video_delay_line.sv | 37 +++
 rtl/video_timing_generator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing constants, total-length helpers and region decode
// for the video timing generator and its delay line.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_COORD_W    = 10;
  localparam int DEF_PIPE_DELAY = 2;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_e;

  function automatic int h_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

  function automatic int v_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

  // Region order along a line or frame:
  // active, front porch, sync, back porch.
  function automatic region_e region_of(
    input int unsigned cnt,
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sw
  );
    region_e r;
    if (cnt < act)
      r = REG_ACTIVE;
    else if (cnt < act + fp)
      r = REG_FRONT;
    else if (cnt < act + fp + sw)
      r = REG_SYNC;
    else
      r = REG_BACK;
    return r;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Enable-gated shift register, DEPTH stages of WIDTH bits.
// Ports: clk/reset/enable, in_data -> out_data. DEPTH=0 is a wire.
module video_delay_line #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             in_vga_clk,
  input  logic             in_reset,
  input  logic             in_enable,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, in_vga_clk,
                         in_reset, in_enable};
    assign out_data = in_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(negedge in_vga_clk) begin
      if (in_reset) begin
        for (int i = 0; i < DEPTH; i++)
          stage[i] <= RESET_VAL;
      end else if (in_enable) begin
        stage[0] <= in_data;
        for (int i = 1; i < DEPTH; i++)
          stage[i] <= stage[i-1];
      end
    end

    assign out_data = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_generator.sv
// Video timing generator: H/V counters, region decode, coordinate
// and strobe registers, delayed {blank_n,h_sync,v_sync} outputs.
// Ports: in_vga_clk (falling edge), in_reset (sync, active-high),
// in_enable (pixel CE); out_pixel_x/y, out_active, out_line_start,
// out_frame_start, out_blank_n, out_h_sync, out_v_sync.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic               in_vga_clk,
  input  logic               in_reset,
  input  logic               in_enable,
  output logic [COORD_W-1:0] out_pixel_x,
  output logic [COORD_W-1:0] out_pixel_y,
  output logic               out_active,
  output logic               out_line_start,
  output logic               out_frame_start,
  output logic               out_blank_n,
  output logic               out_h_sync,
  output logic               out_v_sync
);

  localparam int H_TOTAL =
    h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [COORD_W-1:0] H_LAST =
    COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST =
    COORD_W'(V_TOTAL - 1);

  // {blank_n, h_sync, v_sync} idle: blanked, syncs inactive.
  localparam logic [2:0] SB_IDLE =
    {1'b0, ~H_SYNC_POL, ~V_SYNC_POL};

  if (H_ACTIVE == 0 || V_ACTIVE == 0 ||
      H_SYNC == 0 || V_SYNC == 0) begin : g_bad_zero
    $error("video_timing_generator: zero-width region");
  end

  if (H_TOTAL - 1 >= 2**COORD_W ||
      V_TOTAL - 1 >= 2**COORD_W) begin : g_bad_width
    $error("video_timing_generator: COORD_W too small");
  end

  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  region_e            h_reg;
  region_e            v_reg;
  logic               active;
  logic               h_last;
  logic               v_last;
  logic [2:0]         sb_d;
  logic [2:0]         sb_q;
  logic [2:0]         sb_dly;

  always_comb begin
    h_reg  = region_of(32'(h_count), H_ACTIVE,
                       H_FRONT, H_SYNC);
    v_reg  = region_of(32'(v_count), V_ACTIVE,
                       V_FRONT, V_SYNC);
    active = (h_reg == REG_ACTIVE) &&
             (v_reg == REG_ACTIVE);
    h_last = (h_count == H_LAST);
    v_last = (v_count == V_LAST);
    sb_d   = SB_IDLE;
    sb_d[2] = active;
    if (h_reg == REG_SYNC)
      sb_d[1] = H_SYNC_POL;
    if (v_reg == REG_SYNC)
      sb_d[0] = V_SYNC_POL;
  end

  always_ff @(negedge in_vga_clk) begin
    if (in_reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (in_enable) begin
      if (h_last) begin
        h_count <= '0;
        v_count <= v_last ? '0 : v_count + 1'b1;
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  // Strobes drop on any disabled edge so each pulse
  // is exactly one clock wide regardless of the CE rate.
  always_ff @(negedge in_vga_clk) begin
    if (in_reset) begin
      out_pixel_x     <= '0;
      out_pixel_y     <= '0;
      out_active      <= 1'b0;
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
      sb_q            <= SB_IDLE;
    end else if (in_enable) begin
      out_pixel_x     <= active ? h_count : '0;
      out_pixel_y     <= active ? v_count : '0;
      out_active      <= active;
      out_line_start  <= active && (h_count == '0);
      out_frame_start <= active && (h_count == '0) &&
                         (v_count == '0);
      sb_q            <= sb_d;
    end else begin
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
    end
  end

  video_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SB_IDLE)
  ) u_sync_dly (
    .in_vga_clk (in_vga_clk),
    .in_reset   (in_reset),
    .in_enable  (in_enable),
    .in_data    (sb_q),
    .out_data   (sb_dly)
  );

  assign {out_blank_n, out_h_sync, out_v_sync} = sb_dly;

endmodule
